// File: rtl/alm_pkg.sv
// Shared types and constant helpers for the dynamic-range approximate log multiplier.
package alm_pkg;

  typedef enum logic [1:0] {
    ALM_ADAPT = 2'd0,
    ALM_BASE  = 2'd1,
    ALM_EXACT = 2'd2
  } alm_mode_e;

  // Number of fraction bits dropped below the kept mantissa.
  function automatic int unsigned alm_rem(input int unsigned w, input int unsigned m);
    return w - m;
  endfunction

  // Adaptive compensation fires when the dropped bits sum to at least 7/8 of one full LSB.
  function automatic longint unsigned alm_thresh(input int unsigned rem);
    return (64'd7 << rem) >> 3;
  endfunction

  function automatic alm_mode_e alm_decode_mode(input logic [1:0] mode);
    alm_mode_e m;
    case (mode)
      2'd1:    m = ALM_BASE;
      2'd2:    m = ALM_EXACT;
      default: m = ALM_ADAPT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lod_nbit.sv
// Combinational leading-one detector; reports the index of the highest set bit (0 for zero input).
module lod_nbit #(
  parameter int unsigned W = 16,
  localparam int unsigned KW = $clog2(W)
) (
  input  logic [W-1:0]  i_val,
  output logic [KW-1:0] o_k
);

  always_comb begin
    o_k = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i_val[i]) o_k = KW'(i);
    end
  end

endmodule

// File: rtl/pipelined_dr_alm_approx_mult.sv
// Three-stage dynamic-range approximate logarithmic multiplier with valid/ready flow control,
// runtime compensation mode and a tag carried alongside each operation.
module pipelined_dr_alm_approx_mult
  import alm_pkg::*;
#(
  parameter int unsigned W           = 16,
  parameter int unsigned M_WIDTH     = 5,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned ADAPT_K_MIN = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic [1:0]       i_mode,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2*W-1:0]   o_z,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned KW  = $clog2(W);
  localparam int unsigned FKW = $clog2(2 * W + 1);
  localparam int unsigned FW  = W - 1;
  localparam int unsigned SXW = M_WIDTH + 2;
  localparam int unsigned ZW  = 2 * W;
  localparam int unsigned MW  = 2 * W + 1;
  localparam int unsigned REM = alm_rem(W, M_WIDTH);

  localparam longint unsigned ThreshL = alm_thresh(REM);
  localparam logic [REM:0]    Thresh  = ThreshL[REM:0];
  localparam logic [FKW-1:0]  MK      = FKW'(M_WIDTH);

  localparam logic [MW-1:0] MagPosMax = {2'b00, {(2 * W - 1){1'b1}}};
  localparam logic [MW-1:0] MagNegMax = {2'b01, {(2 * W - 1){1'b0}}};

  logic en;

  // Stage 1 registers
  logic             s1_valid_d, s1_valid_q;
  logic [W-1:0]     s1_abs_a_d, s1_abs_a_q;
  logic [W-1:0]     s1_abs_b_d, s1_abs_b_q;
  logic [KW-1:0]    s1_k_a_d, s1_k_a_q;
  logic [KW-1:0]    s1_k_b_d, s1_k_b_q;
  logic             s1_sign_d, s1_sign_q;
  logic             s1_zero_d, s1_zero_q;
  alm_mode_e        s1_mode_d, s1_mode_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

  // Stage 2 registers
  logic             s2_valid_d, s2_valid_q;
  logic             s2_sign_d, s2_sign_q;
  logic             s2_zero_d, s2_zero_q;
  logic             s2_exact_d, s2_exact_q;
  logic [FKW-1:0]   s2_final_k_d, s2_final_k_q;
  logic [M_WIDTH-1:0] s2_final_x_d, s2_final_x_q;
  logic [ZW-1:0]    s2_prod_d, s2_prod_q;
  logic [TAG_W-1:0] s2_tag_d, s2_tag_q;

  // Stage 3 (output) registers
  logic             s3_valid_d, s3_valid_q;
  logic [ZW-1:0]    s3_z_d, s3_z_q;
  logic [TAG_W-1:0] s3_tag_d, s3_tag_q;

  assign en      = !s3_valid_q || i_ready;
  assign o_ready = en;
  assign o_valid = s3_valid_q;
  assign o_z     = s3_z_q;
  assign o_tag   = s3_tag_q;

  // ---------------------------------------------------------------------------------------------
  // S1: sign, magnitude, leading-one position
  // ---------------------------------------------------------------------------------------------
  logic [W-1:0]  abs_a, abs_b;
  logic [KW-1:0] k_a, k_b;

  always_comb begin
    abs_a = i_a[W-1] ? (~i_a + 1'b1) : i_a;
    abs_b = i_b[W-1] ? (~i_b + 1'b1) : i_b;
  end

  lod_nbit #(.W(W)) u_lod_a (
    .i_val (abs_a),
    .o_k   (k_a)
  );

  lod_nbit #(.W(W)) u_lod_b (
    .i_val (abs_b),
    .o_k   (k_b)
  );

  always_comb begin
    s1_valid_d = i_valid;
    s1_abs_a_d = abs_a;
    s1_abs_b_d = abs_b;
    s1_k_a_d   = k_a;
    s1_k_b_d   = k_b;
    s1_zero_d  = (abs_a == '0) || (abs_b == '0);
    s1_sign_d  = i_a[W-1] ^ i_b[W-1];
    s1_mode_d  = alm_decode_mode(i_mode);
    s1_tag_d   = i_tag;
  end

  // ---------------------------------------------------------------------------------------------
  // S2: normalise, add in the log domain with compensation
  // ---------------------------------------------------------------------------------------------
  logic [KW-1:0]      sh_a, sh_b;
  logic [FW-1:0]      frac_a, frac_b;
  logic [M_WIDTH-1:0] x_a, x_b;
  logic [REM:0]       trunc_sum;
  logic               adapt_ok;
  logic [1:0]         comp;
  logic [SXW-1:0]     sum_x;

  always_comb begin
    sh_a      = KW'(W - 1) - s1_k_a_q;
    sh_b      = KW'(W - 1) - s1_k_b_q;
    // Dropping the MSB of the normalised value leaves the pure fraction.
    frac_a    = FW'(s1_abs_a_q << sh_a);
    frac_b    = FW'(s1_abs_b_q << sh_b);
    x_a       = {frac_a[W-2 -: M_WIDTH-1], 1'b1};
    x_b       = {frac_b[W-2 -: M_WIDTH-1], 1'b1};
    trunc_sum = {1'b0, frac_a[REM-1:0]} + {1'b0, frac_b[REM-1:0]};
    adapt_ok  = (s1_mode_q != ALM_BASE) && (REM > 2) &&
                (32'(s1_k_a_q) >= ADAPT_K_MIN) && (32'(s1_k_b_q) >= ADAPT_K_MIN);
    comp      = (adapt_ok && (trunc_sum >= Thresh)) ? 2'd2 : 2'd1;
    sum_x     = SXW'(x_a) + SXW'(x_b) + SXW'(comp);

    s2_valid_d   = s1_valid_q;
    s2_sign_d    = s1_sign_q;
    s2_zero_d    = s1_zero_q;
    s2_exact_d   = (s1_mode_q == ALM_EXACT);
    s2_final_k_d = FKW'(s1_k_a_q) + FKW'(s1_k_b_q) + FKW'(sum_x[M_WIDTH+1:M_WIDTH]);
    s2_final_x_d = sum_x[M_WIDTH-1:0];
    s2_prod_d    = ZW'(s1_abs_a_q) * ZW'(s1_abs_b_q);
    s2_tag_d     = s1_tag_q;
  end

  // ---------------------------------------------------------------------------------------------
  // S3: antilog, saturate, apply sign
  // ---------------------------------------------------------------------------------------------
  logic [MW-1:0] mant_ext, mag, mag_sat, mag_neg;

  always_comb begin
    mant_ext = MW'({1'b1, s2_final_x_q});
    mag      = '0;
    if (s2_zero_q) begin
      mag = '0;
    end else if (s2_exact_q) begin
      mag = MW'(s2_prod_q);
    end else if (s2_final_k_q >= MK) begin
      mag = mant_ext << (s2_final_k_q - MK);
    end else begin
      mag = mant_ext >> (MK - s2_final_k_q);
    end

    mag_sat = mag;
    if (!s2_sign_q && (mag > MagPosMax)) mag_sat = MagPosMax;
    if (s2_sign_q && (mag > MagNegMax))  mag_sat = MagNegMax;
    mag_neg = ~mag_sat + 1'b1;

    s3_valid_d = s2_valid_q;
    s3_z_d     = (s2_sign_q && !s2_zero_q) ? ZW'(mag_neg) : ZW'(mag_sat);
    s3_tag_d   = s2_tag_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Pipeline registers: the whole pipe moves together on en
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q   <= 1'b0;
      s1_abs_a_q   <= '0;
      s1_abs_b_q   <= '0;
      s1_k_a_q     <= '0;
      s1_k_b_q     <= '0;
      s1_sign_q    <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_mode_q    <= ALM_ADAPT;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_exact_q   <= 1'b0;
      s2_final_k_q <= '0;
      s2_final_x_q <= '0;
      s2_prod_q    <= '0;
      s2_tag_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_z_q       <= '0;
      s3_tag_q     <= '0;
    end else if (en) begin
      s1_valid_q   <= s1_valid_d;
      s1_abs_a_q   <= s1_abs_a_d;
      s1_abs_b_q   <= s1_abs_b_d;
      s1_k_a_q     <= s1_k_a_d;
      s1_k_b_q     <= s1_k_b_d;
      s1_sign_q    <= s1_sign_d;
      s1_zero_q    <= s1_zero_d;
      s1_mode_q    <= s1_mode_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_zero_q    <= s2_zero_d;
      s2_exact_q   <= s2_exact_d;
      s2_final_k_q <= s2_final_k_d;
      s2_final_x_q <= s2_final_x_d;
      s2_prod_q    <= s2_prod_d;
      s2_tag_q     <= s2_tag_d;
      s3_valid_q   <= s3_valid_d;
      s3_z_q       <= s3_z_d;
      s3_tag_q     <= s3_tag_d;
    end
  end

endmodule
